stage_if: RTL and testbench

STAGE_IF -- requirements
Module: stage_if

---
 rtl/stage_if.sv | 119 +++++++++++
 tb/tb_stage_if.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/stage_if.sv
// Instruction fetch stage: drives instruction memory and feeds the IF/ID register.
// A one-entry skid buffer absorbs a fetch that completes while decode stalls.
module stage_if #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic        pc_write_enable,
    input  logic [31:0] pc_write_data,
    output logic        mem_req,
    output logic [31:0] mem_addr,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata,
    output logic [31:0] instruction_o,
    output logic [31:0] pc_o,
    output logic        valid_o
);

    typedef enum logic {RUN, FULL} state_t;

    state_t      state_q;
    logic [31:0] fetch_pc_q;
    logic [31:0] fetch_pc_d;
    logic [31:0] skid_instr_q;
    logic [31:0] skid_pc_q;
    logic        skid_full_q;
    logic        redirect_pending_q;
    logic [31:0] pending_target_q;
    logic [31:0] instr_q;
    logic [31:0] pc_q;
    logic        valid_q;
    logic        mem_req_q;

    logic        ack_ok;
    logic        redir_ok;

    assign mem_req       = mem_req_q;
    assign mem_addr      = {fetch_pc_q[31:2], 2'b00};
    assign instruction_o = instr_q;
    assign pc_o          = pc_q;
    assign valid_o       = valid_q;

    // An ack only counts against a request actually on the bus.
    assign ack_ok   = mem_req_q & mem_ack;
    assign redir_ok = pc_write_enable & valid_q & ~stall;

    always_comb begin
        fetch_pc_d = fetch_pc_q + 32'd4;
        if (redirect_pending_q) begin
            fetch_pc_d = pending_target_q;
        end else if (redir_ok) begin
            fetch_pc_d = pc_write_data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q            <= RUN;
            fetch_pc_q         <= RESET_PC;
            skid_instr_q       <= 32'h0;
            skid_pc_q          <= 32'h0;
            skid_full_q        <= 1'b0;
            redirect_pending_q <= 1'b0;
            pending_target_q   <= 32'h0;
            instr_q            <= 32'h0;
            pc_q               <= 32'h0;
            valid_q            <= 1'b0;
            mem_req_q          <= 1'b0;
        end else begin
            unique case (state_q)
                RUN: begin
                    mem_req_q <= 1'b1;
                    if (ack_ok) begin
                        fetch_pc_q         <= fetch_pc_d;
                        redirect_pending_q <= 1'b0;
                        if (stall) begin
                            skid_instr_q <= mem_rdata;
                            skid_pc_q    <= mem_addr;
                            skid_full_q  <= 1'b1;
                            state_q      <= FULL;
                            mem_req_q    <= 1'b0;
                        end else begin
                            instr_q <= mem_rdata;
                            pc_q    <= mem_addr;
                            valid_q <= 1'b1;
                        end
                    end else if (!stall) begin
                        instr_q <= 32'h0;
                        valid_q <= 1'b0;
                        // Delay slot still in flight: remember the target.
                        if (redir_ok) begin
                            redirect_pending_q <= 1'b1;
                            pending_target_q   <= pc_write_data;
                        end
                    end
                end
                FULL: begin
                    if (!stall) begin
                        instr_q     <= skid_instr_q;
                        pc_q        <= skid_pc_q;
                        valid_q     <= 1'b1;
                        skid_full_q <= 1'b0;
                        state_q     <= RUN;
                        mem_req_q   <= 1'b1;
                        if (redir_ok) begin
                            fetch_pc_q <= pc_write_data;
                        end
                    end
                end
                default: begin
                    state_q   <= RUN;
                    mem_req_q <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_stage_if.sv
// Directed bench for stage_if: reset, streaming, wait states, stall/skid,
// branch delay slot, pending redirect, reset mid-request and PC wrap.
module tb_stage_if;

    logic        clk;
    logic        reset;
    logic        stall;
    logic        pc_write_enable;
    logic [31:0] pc_write_data;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_ack;
    logic [31:0] mem_rdata;
    logic [31:0] instruction_o;
    logic [31:0] pc_o;
    logic        valid_o;

    logic        zero_wait;
    logic        ack_m;
    int          tests;
    int          fails;

    function automatic logic [31:0] imem(input logic [31:0] a);
        return a ^ 32'hA5A5_0000;
    endfunction

    assign mem_ack   = zero_wait ? mem_req : ack_m;
    assign mem_rdata = imem(mem_addr);

    stage_if dut (
        .clk            (clk),
        .reset          (reset),
        .stall          (stall),
        .pc_write_enable(pc_write_enable),
        .pc_write_data  (pc_write_data),
        .mem_req        (mem_req),
        .mem_addr       (mem_addr),
        .mem_ack        (mem_ack),
        .mem_rdata      (mem_rdata),
        .instruction_o  (instruction_o),
        .pc_o           (pc_o),
        .valid_o        (valid_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        tests++;
        assert (got === exp)
        else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, got, exp);
        end
    endtask

    task automatic chk_out(input string tag, input logic v,
                           input logic [31:0] pc);
        chk({tag, ".valid"}, {31'b0, valid_o}, {31'b0, v});
        if (v) begin
            chk({tag, ".pc"}, pc_o, pc);
            chk({tag, ".instr"}, instruction_o, imem(pc));
        end else begin
            chk({tag, ".nop"}, instruction_o, 32'h0);
        end
    endtask

    initial begin
        tests = 0;
        fails = 0;
        reset = 1'b1;
        stall = 1'b0;
        pc_write_enable = 1'b0;
        pc_write_data = 32'h0;
        zero_wait = 1'b0;
        ack_m = 1'b0;

        // Reset state
        tick();
        tick();
        chk("rst.valid", {31'b0, valid_o}, 32'h0);
        chk("rst.req", {31'b0, mem_req}, 32'h0);
        chk("rst.pc", pc_o, 32'h0);
        chk("rst.instr", instruction_o, 32'h0);

        // Zero-wait streaming
        zero_wait = 1'b1;
        reset = 1'b0;
        tick();
        chk("zw.req", {31'b0, mem_req}, 32'h1);
        chk("zw.addr", mem_addr, 32'h0);
        chk("zw.bub", {31'b0, valid_o}, 32'h0);
        tick(); chk_out("zw0", 1'b1, 32'h0);
        tick(); chk_out("zw4", 1'b1, 32'h4);
        tick(); chk_out("zw8", 1'b1, 32'h8);
        tick(); chk_out("zwC", 1'b1, 32'hC);

        // Two wait states per request
        reset = 1'b1;
        zero_wait = 1'b0;
        ack_m = 1'b0;
        tick();
        reset = 1'b0;
        tick();
        chk("ws.addr1", mem_addr, 32'h0);
        tick();
        chk("ws.addr2", mem_addr, 32'h0);
        chk("ws.req2", {31'b0, mem_req}, 32'h1);
        chk_out("ws.b0", 1'b0, 32'h0);
        tick();
        chk("ws.addr3", mem_addr, 32'h0);
        ack_m = 1'b1;
        tick(); chk_out("ws0", 1'b1, 32'h0);
        ack_m = 1'b0;
        chk("ws.addr4", mem_addr, 32'h4);
        tick(); chk_out("ws.b1", 1'b0, 32'h0);
        chk("ws.addr5", mem_addr, 32'h4);
        tick(); chk_out("ws.b2", 1'b0, 32'h0);
        chk("ws.addr6", mem_addr, 32'h4);
        ack_m = 1'b1;
        tick(); chk_out("ws4", 1'b1, 32'h4);

        // Stall while ack for pc 8 arrives
        stall = 1'b1;
        tick(); chk_out("st1", 1'b1, 32'h4);
        chk("st1.req", {31'b0, mem_req}, 32'h0);
        tick(); chk_out("st2", 1'b1, 32'h4);
        chk("st2.req", {31'b0, mem_req}, 32'h0);
        tick(); chk_out("st3", 1'b1, 32'h4);
        stall = 1'b0;
        ack_m = 1'b0;
        tick(); chk_out("st8", 1'b1, 32'h8);
        chk("st.req", {31'b0, mem_req}, 32'h1);
        chk("st.addr", mem_addr, 32'hC);

        // Branch at 0x10 to 0x40
        zero_wait = 1'b1;
        tick(); chk_out("brC", 1'b1, 32'hC);
        tick(); chk_out("br10", 1'b1, 32'h10);
        pc_write_enable = 1'b1;
        pc_write_data = 32'h40;
        tick(); chk_out("br14", 1'b1, 32'h14);
        pc_write_enable = 1'b0;
        tick(); chk_out("br40", 1'b1, 32'h40);
        tick(); chk_out("br44", 1'b1, 32'h44);

        // Redirect to 0x80 while delay slot 0x24 waits
        pc_write_enable = 1'b1;
        pc_write_data = 32'h20;
        tick(); chk_out("pd48", 1'b1, 32'h48);
        pc_write_enable = 1'b0;
        zero_wait = 1'b0;
        ack_m = 1'b1;
        tick(); chk_out("pd20", 1'b1, 32'h20);
        ack_m = 1'b0;
        pc_write_enable = 1'b1;
        pc_write_data = 32'h80;
        tick(); chk_out("pd.b1", 1'b0, 32'h0);
        pc_write_enable = 1'b0;
        chk("pd.flag", {31'b0, dut.redirect_pending_q}, 32'h1);
        chk("pd.tgt", dut.pending_target_q, 32'h80);
        chk("pd.addr", mem_addr, 32'h24);
        tick(); chk_out("pd.b2", 1'b0, 32'h0);
        chk("pd.addr2", mem_addr, 32'h24);
        ack_m = 1'b1;
        tick(); chk_out("pd24", 1'b1, 32'h24);
        chk("pd.clr", {31'b0, dut.redirect_pending_q}, 32'h0);
        chk("pd.addr3", mem_addr, 32'h80);
        tick(); chk_out("pd80", 1'b1, 32'h80);

        // Reset with request outstanding, ack held high
        reset = 1'b1;
        tick();
        chk_out("rr", 1'b0, 32'h0);
        chk("rr.req", {31'b0, mem_req}, 32'h0);
        chk("rr.pc", pc_o, 32'h0);
        reset = 1'b0;
        tick();
        chk("rr.req2", {31'b0, mem_req}, 32'h1);
        chk("rr.addr", mem_addr, 32'h0);
        chk_out("rr.b", 1'b0, 32'h0);

        // Wrap from 0xFFFFFFFC to 0
        ack_m = 1'b0;
        zero_wait = 1'b1;
        tick(); chk_out("wr0", 1'b1, 32'h0);
        pc_write_enable = 1'b1;
        pc_write_data = 32'hFFFF_FFFC;
        tick(); chk_out("wr4", 1'b1, 32'h4);
        pc_write_enable = 1'b0;
        tick(); chk_out("wrF", 1'b1, 32'hFFFF_FFFC);
        tick(); chk_out("wrZ", 1'b1, 32'h0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
